// File: rtl/csa_acc_pkg.sv
// rtl/csa_acc_pkg.sv - shared types, defaults and the majority helper for csa_accumulator
//   csa_state_e : control FSM state encoding
//   DEF_WIDTH/DEF_GUARD/DEF_CHUNK : default operand width, guard bits, CPA chunk width
//   maj()       : single-bit majority, the carry function of a full adder
package csa_acc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_RESOLVE = 2'd2,
    ST_DONE    = 2'd3
  } csa_state_e;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_GUARD = 8;
  localparam int DEF_CHUNK = 8;

  function automatic logic maj(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/csa_row.sv
// rtl/csa_row.sv - parametrised-width 3:2 carry-save compressor row
//   W         : vector width (>= 2)
//   a, b, c   : in  [W-1:0] three addends
//   sum       : out [W-1:0] bitwise a^b^c
//   carry     : out [W-1:0] majority shifted left by one; carry out of bit W-1 dropped
module csa_row
  import csa_acc_pkg::*;
#(
  parameter int W = 40
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  logic [W-2:0] maj_lo;

  assign sum = a ^ b ^ c;

  // Only bits 0..W-2 produce a carry that stays inside the vector, so the
  // top bit's majority is never computed: the result wraps mod 2^W.
  for (genvar i = 0; i < W - 1; i++) begin : g_maj
    assign maj_lo[i] = maj(a[i], b[i], c[i]);
  end

  assign carry = {maj_lo, 1'b0};

endmodule

// File: rtl/csa_accumulator.sv
// rtl/csa_accumulator.sv - carry-save accumulator with chunked carry-propagate resolve
//   Optional feature: define CSA_ACC_SIGNED_EN to sign-extend operands (default zero-extends).
//   clk, rst  : in  clock, synchronous active-high reset
//   in_valid  : in  operand beat offered        in_ready : out beat accepted this cycle
//   in_data   : in  [WIDTH-1:0] operand         in_last  : in  final beat of packet
//   out_valid : out resolved sum available      out_ready: in  downstream accepts sum
//   out_data  : out [ACC_W-1:0] resolved sum    busy     : out packet in progress
module csa_accumulator
  import csa_acc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int GUARD = DEF_GUARD,
  parameter int CHUNK = DEF_CHUNK,
  localparam int ACC_W = WIDTH + GUARD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             busy
);

  localparam int N_CHUNK = ACC_W / CHUNK;
  localparam int IDX_W   = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1;

  if ((ACC_W % CHUNK) != 0) begin : g_bad_chunk
    $error("csa_accumulator: WIDTH+GUARD must be a multiple of CHUNK");
  end

  csa_state_e       state_q, state_d;
  logic [ACC_W-1:0] s_q, s_d;
  logic [ACC_W-1:0] c_q, c_d;
  logic             cy_q, cy_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [ACC_W-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;

  logic [ACC_W-1:0] x_ext;
  logic [ACC_W-1:0] s_nxt;
  logic [ACC_W-1:0] c_nxt;
  logic [CHUNK-1:0] s_chunk;
  logic [CHUNK-1:0] c_chunk;
  logic [CHUNK:0]   chunk_sum;
  logic             accept;
  logic             handshake;

`ifdef CSA_ACC_SIGNED_EN
  assign x_ext = {{GUARD{in_data[WIDTH-1]}}, in_data};
`else
  assign x_ext = {{GUARD{1'b0}}, in_data};
`endif

  csa_row #(
    .W(ACC_W)
  ) u_row (
    .a    (s_q),
    .b    (c_q),
    .c    (x_ext),
    .sum  (s_nxt),
    .carry(c_nxt)
  );

  assign in_ready  = ~rst & ((state_q == ST_IDLE) | (state_q == ST_ACCUM));
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  assign accept    = in_valid & in_ready;
  assign handshake = out_valid_q & out_ready;

  // Current chunk of the carry-propagate add; the chunk carry is held in cy_q
  // so each cycle's adder is only CHUNK+1 bits wide.
  assign s_chunk   = s_q[int'(idx_q) * CHUNK +: CHUNK];
  assign c_chunk   = c_q[int'(idx_q) * CHUNK +: CHUNK];
  assign chunk_sum = {1'b0, s_chunk} + {1'b0, c_chunk} + {{CHUNK{1'b0}}, cy_q};

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    c_d         = c_q;
    cy_d        = cy_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;

    case (state_q)
      ST_IDLE, ST_ACCUM: begin
        if (accept) begin
          s_d     = s_nxt;
          c_d     = c_nxt;
          cy_d    = 1'b0;
          idx_d   = '0;
          state_d = in_last ? ST_RESOLVE : ST_ACCUM;
        end
      end
      ST_RESOLVE: begin
        out_data_d[int'(idx_q) * CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
        cy_d = chunk_sum[CHUNK];
        if (idx_q == IDX_W'(N_CHUNK - 1)) begin
          idx_d   = '0;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        // out_valid is registered from the DONE state, so it appears one
        // edge after the last chunk has been written into out_data.
        if (handshake) begin
          state_d = ST_IDLE;
          s_d     = '0;
          c_d     = '0;
          cy_d    = 1'b0;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      s_q         <= '0;
      c_q         <= '0;
      cy_q        <= 1'b0;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      c_q         <= c_d;
      cy_q        <= cy_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: doc/csa_accumulator.md
CSA_ACCUMULATOR -- requirements
Module: csa_accumulator

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits.
REQ-002 Parameter GUARD, default 8, overflow guard bits; ACC_W = WIDTH+GUARD.
REQ-003 Parameter CHUNK, default 8, result bits resolved per cycle; ACC_W SHALL be a multiple of CHUNK (elaboration error otherwise); N_CHUNK = ACC_W/CHUNK.
REQ-004 clk  input  1  sole clock; all state SHALL update on rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 in_valid  input  1  operand beat offered.
REQ-007 in_ready  output  1  block accepts operand this cycle.
REQ-008 in_data  input  WIDTH  operand.
REQ-009 in_last  input  1  marks final operand of a packet.
REQ-010 out_valid  output  1  resolved sum available.
REQ-011 out_ready  input  1  downstream accepts sum.
REQ-012 out_data  output  ACC_W  resolved sum.
REQ-013 busy  output  1  high in ACCUM, RESOLVE or DONE.

Function
REQ-014 States SHALL be IDLE, ACCUM, RESOLVE, DONE.
REQ-015 in_ready SHALL be 1 in IDLE/ACCUM and 0 in RESOLVE/DONE and while rst is high; operand accepted iff in_valid & in_ready at the edge.
REQ-016 Accepted beat: X = operand extended to ACC_W; S <= S^C^X; C <= {maj(S,C,X)[ACC_W-2:0],1'b0}; carry out of bit ACC_W-1 discarded (sum mod 2^ACC_W); no carry propagation in accumulate path.
REQ-017 Accept without in_last: IDLE->ACCUM or ACCUM->ACCUM; accept with in_last: ->RESOLVE.
REQ-018 RESOLVE: one chunk per cycle, k=0..N_CHUNK-1, out_data[k] = S[k]+C[k]+cy, cy registered, cy=0 at k=0; after chunk N_CHUNK-1 -> DONE.
REQ-019 out_valid SHALL rise exactly N_CHUNK+1 edges after the edge accepting the in_last beat (6 cycles at defaults) and equal 1 only in DONE.
REQ-020 DONE: out_data SHALL hold stable until out_valid & out_ready; on that edge S, C, cy cleared, state -> IDLE; in_ready rises the following cycle.
REQ-021 out_data SHALL hold its last value outside DONE; only its bits within resolved chunks may change during RESOLVE.
REQ-022 Single-beat packet (in_last on first beat) SHALL yield out_data = X.
REQ-023 in_valid/in_last while in_ready=0 SHALL be ignored with no state change.

Reset
REQ-024 With rst high at an edge: state IDLE, S=0, C=0, cy=0, chunk index 0, out_valid=0, out_data=0, busy=0, in_ready=0 for that cycle.
REQ-025 Reset in any state, including mid-RESOLVE or DONE with out_valid high, SHALL discard the packet; no out_valid for it.

Configuration
REQ-026 Macro CSA_ACC_SIGNED_EN defined: in_data sign-extended to ACC_W, out_data two's-complement mod 2^ACC_W.
REQ-027 Macro undefined: in_data zero-extended; out_data unsigned mod 2^ACC_W; no other behaviour differs.

Structure
REQ-028 Package csa_acc_pkg SHALL hold state enum type, default WIDTH/GUARD/CHUNK constants and the maj() function.
REQ-029 Sub-module csa_row (parametrised-width 3:2 compressor row, three vector inputs, sum and shifted-carry outputs) SHALL implement REQ-016; control FSM and chunked CPA stay in csa_accumulator.

Verification
REQ-030 Defaults, beats 5,7,9 (last on 9), out_ready=1 -> out_data=21, out_valid exactly 6 cycles after last accept, held 1 cycle.
REQ-031 Single beat 0xFFFFFFFF with in_last -> out_data=0x00FFFFFFFF unsigned; 0xFFFFFFFFFF with CSA_ACC_SIGNED_EN.
REQ-032 300 beats of 0xFFFFFFFF unsigned -> out_data = (300*0xFFFFFFFF) mod 2^40 = 0x2BFFFFFED4 (wrap check).
REQ-033 out_ready held 0 for 10 cycles in DONE -> out_data stable, in_ready=0, in_valid pulses ignored; release -> IDLE, next packet of beat 1 -> 1.
REQ-034 rst pulsed on third RESOLVE cycle -> no out_valid, all outputs at reset values; next packet 2,3 -> 5.
REQ-035 CHUNK=4, WIDTH=12, GUARD=4, beats 0xFFF,0x001 -> out_data=0x1000, out_valid 5 cycles after last accept.
